// File: rtl/bcd_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_addsub_pipe_if
// Description : Operand/result bundle for the pipelined BCD adder/subtractor.
//               master = operand source / result sink, slave = arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_addsub_pipe_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  in_valid;
    logic                  sub;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  Cin;
    logic [4*DIGITS-1:0]   S;
    logic                  Cout;
    logic                  err;
    logic                  out_valid;

    modport master (
        output en, in_valid, sub, A, B, Cin,
        input  S, Cout, err, out_valid
    );

    modport slave (
        input  en, in_valid, sub, A, B, Cin,
        output S, Cout, err, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/bcd_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bcd_addsub_pipe
// Description : Fully pipelined N-digit BCD adder/subtractor, one decimal
//               digit resolved per stage. Subtraction uses the nine's
//               complement of B with an inverted carry-in. Global stall (en),
//               valid pipeline and invalid-digit flag travel with each op.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_addsub_pipe #(
    parameter int DIGITS  = 4,
    parameter int REG_OUT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bcd_addsub_pipe_if.slave bus
);

    localparam int W = 4 * DIGITS;

    // One BCD digit: returns {carry_out, sum_digit}; sums above 9 are
    // corrected by +6 (mod 16). Invalid input nibbles go through unchanged rule.
    function automatic logic [4:0] f_digit(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       c);
        logic [4:0] t;
        t = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        if (t > 5'd9) f_digit = {1'b1, t[3:0] + 4'd6};
        else          f_digit = {1'b0, t[3:0]};
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: operand capture with nine's complement of B in subtract mode
    // ------------------------------------------------------------------
    logic [W-1:0] w_b_pre;
    logic         w_err_in;
    logic [W-1:0] r_a0;
    logic [W-1:0] r_b0;
    logic         r_c0;
    logic         r_v0;
    logic         r_e0;

    // Pre-complement B and flag any nibble above 9 in either operand
    always_comb begin
        w_b_pre  = '0;
        w_err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_b_pre[4*i +: 4] = bus.sub ? (4'd9 - bus.B[4*i +: 4]) : bus.B[4*i +: 4];
            if ((bus.A[4*i +: 4] > 4'd9) || (bus.B[4*i +: 4] > 4'd9)) begin
                w_err_in = 1'b1;
            end
        end
    end

    // Capture register; data only loads for real operations so bubbles keep it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_a0 <= '0;
            r_b0 <= '0;
            r_c0 <= 1'b0;
            r_e0 <= 1'b0;
        end else if (bus.en) begin
            r_v0 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a0 <= bus.A;
                r_b0 <= w_b_pre;
                r_c0 <= bus.Cin ^ bus.sub;
                r_e0 <= w_err_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit stages: stage k resolves digit k. Unused operand digits shrink
    // by one nibble per stage; result digits grow by one (skew buffer).
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        localparam int AW = 4 * (DIGITS - k);

        logic [AW-1:0]      w_a_in;
        logic [AW-1:0]      w_b_in;
        logic               w_c_in;
        logic               w_v_in;
        logic               w_e_in;
        logic [4:0]         w_sum;
        logic [4*(k+1)-1:0] w_s_next;
        logic [4*(k+1)-1:0] r_s;
        logic               r_c;
        logic               r_v;
        logic               r_e;

        if (k == 0) begin : g_src_cap
            assign w_a_in   = r_a0;
            assign w_b_in   = r_b0;
            assign w_c_in   = r_c0;
            assign w_v_in   = r_v0;
            assign w_e_in   = r_e0;
            assign w_s_next = w_sum[3:0];
        end else begin : g_src_prev
            assign w_a_in   = g_dig[k-1].g_fwd.r_a;
            assign w_b_in   = g_dig[k-1].g_fwd.r_b;
            assign w_c_in   = g_dig[k-1].r_c;
            assign w_v_in   = g_dig[k-1].r_v;
            assign w_e_in   = g_dig[k-1].r_e;
            assign w_s_next = {w_sum[3:0], g_dig[k-1].r_s};
        end

        assign w_sum = f_digit(w_a_in[3:0], w_b_in[3:0], w_c_in);

        // Result digits, carry and error advance together with their op
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_s <= '0;
                r_c <= 1'b0;
                r_e <= 1'b0;
            end else if (bus.en) begin
                r_v <= w_v_in;
                if (w_v_in) begin
                    r_s <= w_s_next;
                    r_c <= w_sum[4];
                    r_e <= w_e_in;
                end
            end
        end

        if (k < DIGITS - 1) begin : g_fwd
            logic [AW-5:0] r_a;
            logic [AW-5:0] r_b;

            // Forward the operand digits that later stages still need
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (bus.en && w_v_in) begin
                    r_a <= w_a_in[AW-1:4];
                    r_b <= w_b_in[AW-1:4];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output: optional register; bubbles never overwrite held results
    // ------------------------------------------------------------------
    logic [W-1:0] w_s_last;
    logic         w_c_last;
    logic         w_e_last;
    logic         w_v_last;

    assign w_s_last = g_dig[DIGITS-1].r_s;
    assign w_c_last = g_dig[DIGITS-1].r_c;
    assign w_e_last = g_dig[DIGITS-1].r_e;
    assign w_v_last = g_dig[DIGITS-1].r_v;

    if (REG_OUT != 0) begin : g_reg_out
        logic [W-1:0] r_s_out;
        logic         r_cout;
        logic         r_err;
        logic         r_ov;

        // Registered result; loads only when a valid op leaves the last stage
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ov    <= 1'b0;
                r_s_out <= '0;
                r_cout  <= 1'b0;
                r_err   <= 1'b0;
            end else if (bus.en) begin
                r_ov <= w_v_last;
                if (w_v_last) begin
                    r_s_out <= w_s_last;
                    r_cout  <= w_c_last;
                    r_err   <= w_e_last;
                end
            end
        end

        assign bus.S         = r_s_out;
        assign bus.Cout      = r_cout;
        assign bus.err       = r_err;
        assign bus.out_valid = r_ov;
    end else begin : g_comb_out
        assign bus.S         = w_s_last;
        assign bus.Cout      = w_c_last;
        assign bus.err       = w_e_last;
        assign bus.out_valid = w_v_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_addsub_pipe
// Description : Scoreboard bench for bcd_addsub_pipe (DIGITS=4, REG_OUT=1).
//               Directed cases carry literal expected results; random cases
//               use a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_addsub_pipe;

    localparam int D   = 4;
    localparam int W   = 4 * D;
    localparam int LAT = D + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_addsub_pipe_if #(.DIGITS(D)) bus ();

    bcd_addsub_pipe #(.DIGITS(D), .REG_OUT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         e;
        int           cap;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           edge_cnt = 0;
    logic         l_adv    = 1'b0;
    logic         l_rst    = 1'b1;
    logic [W+2:0] snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Reference: plain decimal arithmetic when all digits are legal,
    // otherwise the digit-wise correction rule on raw nibbles.
    function automatic void model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, output logic [W-1:0] s,
                                  output logic cout, output logic err);
        int va, vb, r, p, na, nb;
        logic c;
        int t;
        err = 1'b0; va = 0; vb = 0; p = 1; s = '0; cout = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            na = int'(a[4*i +: 4]);
            nb = int'(b[4*i +: 4]);
            if (na > 9 || nb > 9) err = 1'b1;
            va = va * 10 + na;
            vb = vb * 10 + nb;
            p  = p * 10;
        end
        if (!err) begin
            r    = sub ? (va - vb - int'(cin)) : (va + vb + int'(cin));
            cout = sub ? (r >= 0) : (r >= p);
            r    = (r + p) % p;
            for (int i = 0; i < D; i++) begin
                s[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end else begin
            c = sub ^ cin;
            for (int i = 0; i < D; i++) begin
                na = int'(a[4*i +: 4]);
                nb = sub ? ((9 - int'(b[4*i +: 4])) & 15) : int'(b[4*i +: 4]);
                t  = na + nb + int'(c);
                if (t > 9) begin s[4*i +: 4] = 4'((t + 6) & 15); c = 1'b1; end
                else       begin s[4*i +: 4] = 4'(t);            c = 1'b0; end
            end
            cout = c;
        end
    endfunction

    function automatic logic [W-1:0] rnd_bcd();
        logic [W-1:0] v;
        int idx;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 11) == 0) begin
            idx = int'($urandom_range(0, D - 1));
            v[4*idx +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    task automatic apply(input logic en, input logic v, input logic sub,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.en = en; bus.in_valid = v; bus.sub = sub; bus.A = a; bus.B = b; bus.Cin = cin;
    endtask

    // Random/model-driven cycle
    task automatic drive(input logic en, input logic v, input logic sub,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        apply(en, v, sub, a, b, cin);
        if (en && v) begin
            model(sub, a, b, cin, e.s, e.c, e.e);
            e.cap = edge_cnt + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Directed cycle with literal expected result
    task automatic drive_k(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] xs, input logic xc, input logic xe);
        exp_t e;
        apply(1'b1, 1'b1, sub, a, b, cin);
        e.s = xs; e.c = xc; e.e = xe; e.cap = edge_cnt + 1;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    // Edge bookkeeping: which edges advanced the pipeline
    always @(posedge clk) begin
        l_adv <= bus.en && !rst;
        l_rst <= rst;
        if (bus.en && !rst) edge_cnt <= edge_cnt + 1;
    end

    // Monitor: pop on each newly presented result; check hold when stalled
    always @(negedge clk) begin
        if (l_adv && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("S", bus.S, mon_e.s);
                chk("Cout", bus.Cout, mon_e.c);
                chk("err", bus.err, mon_e.e);
                chk("latency", edge_cnt - mon_e.cap, LAT);
            end
        end
        if (!l_adv && !l_rst) chk("stall_hold", {bus.S, bus.Cout, bus.err, bus.out_valid}, snap);
        snap = {bus.S, bus.Cout, bus.err, bus.out_valid};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic r_en;
        apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle after reset: everything reads zero
        repeat (4) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
            chk("idle_S", bus.S, 0);
            chk("idle_Cout", bus.Cout, 0);
            chk("idle_err", bus.err, 0);
            chk("idle_valid", bus.out_valid, 0);
        end

        // Directed add/sub and wrap-around cases
        drive_k(1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        drive_k(1'b0, 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        drive_k(1'b1, 16'h0500, 16'h0123, 1'b0, 16'h0377, 1'b1, 1'b0);
        drive_k(1'b1, 16'h0123, 16'h0500, 1'b0, 16'h9623, 1'b0, 1'b0);
        drive_k(1'b0, 16'h0005, 16'h0007, 1'b0, 16'h0012, 1'b0, 1'b0);
        drive_k(1'b0, 16'h0048, 16'h0005, 1'b0, 16'h0053, 1'b0, 1'b0);
        drive_k(1'b0, 16'h0111, 16'h0222, 1'b1, 16'h0334, 1'b0, 1'b0);
        drive_k(1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        drive_k(1'b1, 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b0, 1'b0);
        drive_k(1'b0, 16'h00A4, 16'h0004, 1'b0, 16'h0108, 1'b0, 1'b1);
        drive_k(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();

        // Stall with two operations in flight; offered inputs must be ignored
        drive_k(1'b0, 16'h0021, 16'h0034, 1'b0, 16'h0055, 1'b0, 1'b0);
        drive_k(1'b0, 16'h0700, 16'h0300, 1'b0, 16'h1000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 16'h4444, 16'h3333, 1'b0);
        drain();

        // Randomised traffic with bubbles and random stalls
        for (int n = 0; n < 120; n++) begin
            r_en = ($urandom_range(0, 7) != 0);
            drive(r_en, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  rnd_bcd(), rnd_bcd(), 1'($urandom_range(0, 1)));
        end
        drain();

        // Reset with three operations in flight: none may emerge
        drive(1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'h5000, 16'h0001, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'h0009, 16'h0009, 1'b1);
        q.delete();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        repeat (8) drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("post_rst_valid", bus.out_valid, 0);
        chk("post_rst_S", bus.S, 0);
        chk("post_rst_Cout", bus.Cout, 0);
        chk("post_rst_err", bus.err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
